// File: rtl/bin2bcd_conv_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Contents:
//   state_t           - converter FSM state encoding (IDLE / SHIFT / LOAD)
//   BCD_ADD3_THRESH   - nibble value at which the add-3 correction applies
//   BCD_ADJUST        - correction added to a nibble before each shift
//   BCD_SAT_NIBBLE    - digit shown on every position when the value overflows
//   cnt_width()       - width of the bit counter that must hold BIN_W
package bin2bcd_conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJUST      = 4'd3;
  localparam logic [3:0] BCD_SAT_NIBBLE  = 4'h9;

  // Counter must represent the value BIN_W itself, hence clog2(BIN_W+1).
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bin2bcd_conv_add3.sv
// bcd_add3: combinational nibble adjuster used by the shift-and-add-3
// converter. A nibble of 5 or more is corrected by +3 so that the following
// left shift carries correctly into the next decimal digit.
// Ports:
//   din  - BCD nibble before adjustment
//   dout - adjusted nibble (din >= 5 ? din + 3 : din)
module bcd_add3
  import bin2bcd_conv_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Add-3 correction for one decimal digit.
  always_comb begin
    dout = din;
    if (din >= BCD_ADD3_THRESH) begin
      dout = din + BCD_ADJUST;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/bin2bcd_conv.sv
// bin2bcd_conv: sequential binary-to-BCD converter (shift-and-add-3, one bit
// per clock) feeding the multiplexed 7-segment display stage. The result is
// only updated on the final LOAD edge, so the display never sees partial
// values. Values above 10^DIS_NUM-1 are flagged and shown as all nines.
// Parameters:
//   DIS_NUM - number of display digits (output is DIS_NUM*4 bits)
//   BIN_W   - binary input width, 1 .. 3*DIS_NUM+3
// Ports:
//   i_clk        - clock, rising edge
//   i_rst        - asynchronous active-low reset
//   i_start      - conversion request, honoured only while idle
//   i_bin        - binary value, captured with an accepted i_start
//   o_busy       - high while a conversion is in progress
//   o_done       - one-cycle pulse when a new result is presented
//   o_overflow   - value exceeded the displayable range (held with result)
//   o_bcd_data   - packed BCD, digit 0 in bits [3:0]
module bin2bcd_conv
  import bin2bcd_conv_pkg::*;
#(
  parameter int DIS_NUM = 4,
  parameter int BIN_W   = 14
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [BIN_W-1:0]       i_bin,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_overflow,
  output logic [DIS_NUM*4-1:0]   o_bcd_data
);

  // One spare digit above the display width holds the overflow information.
  localparam int INT_DIG = DIS_NUM + 1;
  localparam int BCD_W   = INT_DIG * 4;
  localparam int OUT_W   = DIS_NUM * 4;
  localparam int CNT_W   = cnt_width(BIN_W);

  // INT_DIG nibbles can only hold 2^BIN_W-1 when BIN_W <= 3*DIS_NUM+3.
  if (BIN_W < 1 || BIN_W > 3 * DIS_NUM + 3) begin : g_bad_bin_w
    $error("bin2bcd_conv: BIN_W out of range 1 .. 3*DIS_NUM+3");
  end

  state_t                 state_r;
  state_t                 state_nx_s;
  logic                   capture_s;
  logic                   shift_s;
  logic                   load_s;
  logic [BIN_W-1:0]       bin_r;
  logic [BCD_W-1:0]       bcd_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [BCD_W-1:0]       adj_s;
  logic [BCD_W+BIN_W-1:0] shifted_s;
  logic                   ovf_s;
  logic                   busy_r;
  logic                   done_r;
  logic                   overflow_r;
  logic [OUT_W-1:0]       bcd_out_r;

  // All digits are corrected in parallel; there is no carry between nibbles.
  for (genvar g = 0; g < INT_DIG; g++) begin : g_adj
    bcd_add3 u_add3 (
      .din  (bcd_r[g*4 +: 4]),
      .dout (adj_s[g*4 +: 4])
    );
  end

  // The binary MSB moves into the BCD LSB as the whole register shifts.
  assign shifted_s = {adj_s, bin_r} << 1'b1;
  assign ovf_s     = (bcd_r[BCD_W-1 -: 4] != 4'd0);

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic and datapath control strobes.
  always_comb begin
    state_nx_s = state_r;
    capture_s  = 1'b0;
    shift_s    = 1'b0;
    load_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          capture_s  = 1'b1;
          state_nx_s = ST_SHIFT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shift_s = 1'b1;
        // Counter value 1 here means it reaches 0 with this shift.
        if (cnt_r == CNT_W'(1'b1)) begin
          state_nx_s = ST_LOAD;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_LOAD: begin
        load_s     = 1'b1;
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Working register: capture, shift-and-add-3, bit counter.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      bin_r <= {BIN_W{1'b0}};
      bcd_r <= {BCD_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (capture_s) begin
      bin_r <= i_bin;
      bcd_r <= {BCD_W{1'b0}};
      cnt_r <= CNT_W'(BIN_W);
    end else if (shift_s) begin
      bin_r <= shifted_s[BIN_W-1:0];
      bcd_r <= shifted_s[BCD_W+BIN_W-1:BIN_W];
      cnt_r <= cnt_r - CNT_W'(1'b1);
    end else begin
      bin_r <= bin_r;
      bcd_r <= bcd_r;
      cnt_r <= cnt_r;
    end
  end

  // Registered outputs; result and overflow change only on the LOAD edge.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
      bcd_out_r  <= {OUT_W{1'b0}};
    end else begin
      busy_r <= (state_nx_s != ST_IDLE);
      done_r <= load_s;
      if (load_s) begin
        overflow_r <= ovf_s;
        if (ovf_s) begin
          bcd_out_r <= {DIS_NUM{BCD_SAT_NIBBLE}};
        end else begin
          bcd_out_r <= bcd_r[OUT_W-1:0];
        end
      end else begin
        overflow_r <= overflow_r;
        bcd_out_r  <= bcd_out_r;
      end
    end
  end

  assign o_busy     = busy_r;
  assign o_done     = done_r;
  assign o_overflow = overflow_r;
  assign o_bcd_data = bcd_out_r;

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Self-checking bench for bin2bcd_conv with default parameters
// (DIS_NUM=4, BIN_W=14). Expected results come from a decimal-digit model.
module tb_bin2bcd_conv;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [13:0] i_bin;
  logic        o_busy;
  logic        o_done;
  logic        o_overflow;
  logic [15:0] o_bcd_data;

  int errors = 0;
  int checks = 0;

  bin2bcd_conv #(.DIS_NUM(4), .BIN_W(14)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_bin      (i_bin),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_overflow (o_overflow),
    .o_bcd_data (o_bcd_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference: decimal digits of v, or all nines when v > 9999.
  function automatic logic [15:0] model_bcd(input int v);
    logic [15:0] r;
    int          t;
    r = 16'h0000;
    if (v > 9999) begin
      r = 16'h9999;
    end else begin
      t = v;
      for (int d = 0; d < 4; d++) begin
        r[d*4 +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end
    return r;
  endfunction

  function automatic logic model_ovf(input int v);
    return (v > 9999);
  endfunction

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Pulse i_start for the edge E0, then scramble i_bin.
  task automatic start_conv(input int v);
    i_bin   = 14'(v);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_bin   = 14'($urandom_range(0, 16383));
  endtask

  // Advance until o_done is seen (bounded); counts edges and busy samples.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc      = 0;
    busy_cnt = 0;
    while (!o_done && cyc < 40) begin
      if (o_busy) busy_cnt++;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset;
    i_rst   = 1'b0;
    i_start = 1'b0;
    i_bin   = 14'd0;
    #12;
    checks++;
    if ({o_busy, o_done, o_overflow, o_bcd_data} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b ovf=%b bcd=%h required all 0",
               o_busy, o_done, o_overflow, o_bcd_data);
    end
    i_rst = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_basic;
    int cyc, busy_cnt;
    start_conv(1234);
    wait_done(cyc, busy_cnt);
    checks++;
    if (cyc !== 15 || o_done !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges done=%b required 15 edges done=1", cyc, o_done);
    end
    checks++;
    if (busy_cnt !== 15 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: got %0d busy cycles (busy in done cycle=%b) required 15 and 0",
               busy_cnt, o_busy);
    end
    checks++;
    if (o_bcd_data !== 16'h1234 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_value: got %h ovf=%b required 1234 ovf=0", o_bcd_data, o_overflow);
    end
    tick();
    checks++;
    if (o_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width: got done=%b after one cycle required 0", o_done);
    end
    tick();
    tick();
    checks++;
    if (o_bcd_data !== 16'h1234) begin
      errors++;
      $display("FAIL basic_hold: got %h required 1234", o_bcd_data);
    end
  endtask

  task automatic test_values;
    int vals[$];
    int cyc, busy_cnt;
    vals = '{0, 9, 10, 9999, 10000, 16383};
    for (int k = 0; k < 16; k++) vals.push_back(int'($urandom_range(0, 16383)));
    foreach (vals[k]) begin
      start_conv(vals[k]);
      wait_done(cyc, busy_cnt);
      checks++;
      if (o_done !== 1'b1 || o_bcd_data !== model_bcd(vals[k]) ||
          o_overflow !== model_ovf(vals[k])) begin
        errors++;
        $display("FAIL value_%0d: got bcd=%h ovf=%b done=%b required bcd=%h ovf=%b done=1",
                 vals[k], o_bcd_data, o_overflow, o_done, model_bcd(vals[k]), model_ovf(vals[k]));
      end
      tick();
    end
  endtask

  task automatic test_start_while_busy;
    int dones = 0;
    start_conv(4321);
    for (int k = 0; k < 4; k++) tick();
    i_start = 1'b1;
    i_bin   = 14'd55;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (o_done) begin
        dones++;
        checks++;
        if (o_bcd_data !== 16'h4321 || o_overflow !== 1'b0) begin
          errors++;
          $display("FAIL busy_start_value: got %h ovf=%b required 4321 ovf=0",
                   o_bcd_data, o_overflow);
        end
      end
      tick();
    end
    checks++;
    if (dones !== 1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_dones: got %0d done pulses busy=%b required 1 and 0", dones, o_busy);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, busy_cnt;
    start_conv(77);
    wait_done(cyc, busy_cnt);
    checks++;
    if (o_done !== 1'b1 || o_bcd_data !== 16'h0077) begin
      errors++;
      $display("FAIL b2b_first: got bcd=%h done=%b required 0077 done=1", o_bcd_data, o_done);
    end
    i_start = 1'b1;
    i_bin   = 14'd8000;
    tick();
    i_start = 1'b0;
    i_bin   = 14'($urandom_range(0, 16383));
    cyc = 1;
    while (!o_done && cyc < 40) begin
      checks++;
      if (o_bcd_data !== 16'h0077) begin
        errors++;
        $display("FAIL b2b_hold: got %h at cycle %0d required 0077", o_bcd_data, cyc);
      end
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 16 || o_done !== 1'b1 || o_bcd_data !== 16'h8000) begin
      errors++;
      $display("FAIL b2b_second: got %0d cycles bcd=%h done=%b required 16 cycles 8000 done=1",
               cyc, o_bcd_data, o_done);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    int cyc, busy_cnt;
    start_conv(5678);
    for (int k = 0; k < 6; k++) tick();
    @(posedge i_clk);
    #3;
    i_rst = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_done, o_overflow, o_bcd_data} !== 19'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b ovf=%b bcd=%h required all 0",
               o_busy, o_done, o_overflow, o_bcd_data);
    end
    tick();
    tick();
    i_rst = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if (o_done || o_busy) dones++;
      tick();
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d active cycles after reset required 0", dones);
    end
    start_conv(42);
    wait_done(cyc, busy_cnt);
    checks++;
    if (o_done !== 1'b1 || o_bcd_data !== 16'h0042 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_next: got bcd=%h ovf=%b done=%b required 0042 ovf=0 done=1",
               o_bcd_data, o_overflow, o_done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
